circle_raster_gen: RTL
======================

Name: circle_raster_gen

Overview:
- Parametrised next-generation circle rasteriser for the 2D shape GPU.
- Accepts one job at a time: centre, radius, mode and colour.
- Streams pixels to the framebuffer writer over a valid/ready interface, with backpressure and screen-edge clipping.
- Supports filled mode (exact scanline spans, no duplicate pixels) and outline mode (midpoint 8-way symmetry), plus job abort and an accepted-pixel counter.

Parameters:
- COORD_W, 8, width of xc/yc/r/px/py.
- COLOR_W, 24, pixel colour width.
- SCREEN_W, 256, visible columns; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 256, visible rows; pixels with y >= SCREEN_H are clipped.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  cancel the current job.
- xc  in  COORD_W  centre x, unsigned.
- yc  in  COORD_W  centre y, unsigned.
- r  in  COORD_W  radius, unsigned.
- fill_enable  in  1  1 = filled, 0 = outline.
- color  in  COLOR_W  job colour.
- busy  out  1  high from the cycle after start is accepted until done or abort.
- pixel_valid  out  1  pixel available.
- pixel_ready  in  1  sink accepts the pixel.
- px  out  COORD_W  pixel x.
- py  out  COORD_W  pixel y.
- pixel_color  out  COLOR_W  latched job colour.
- done  out  1  one-cycle pulse at job end.
- pixel_count  out  2*COORD_W+2  pixels accepted in the current or last job.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, job registers cleared.
- Job acceptance:
  - start in IDLE latches xc, yc, r, fill_enable and color, clears pixel_count and sets busy next cycle.
  - start while busy is ignored.
- Arithmetic:
  - Internal coordinates are signed, COORD_W+2 bits.
  - Squares and the midpoint error term use 2*COORD_W+3 bits signed.
  - No wrap-around: any candidate with x<0, y<0, x>=SCREEN_W or y>=SCREEN_H is clipped.
  - A clipped candidate occupies one cycle with pixel_valid low and is not counted.
- States: IDLE, ROW_INIT, SPAN, OCT, STEP, FINISH.
- Fill mode:
  - Rows go from dy=-r to +r, ascending y; x ascends within each row.
  - Half-width w is maintained incrementally, one adjust per cycle in ROW_INIT.
  - For dy<=0: while (w+1)^2+dy^2<=r^2, w++.
  - For dy>0: while w^2+dy^2>r^2, w--.
  - SPAN emits x = xc-w .. xc+w at y = yc+dy. The last row goes to FINISH.
- Outline mode:
  - Initial values: x=0, y=r, d=1-r.
  - OCT emits 8 candidates in this fixed order: (xc+x,yc+y), (xc-x,yc+y), (xc+x,yc-y), (xc-x,yc-y), (xc+y,yc+x), (xc-y,yc+x), (xc+y,yc-x), (xc-y,yc-x).
  - Duplicates are emitted as generated.
  - STEP update: if d<0 then d+=2x+3, else d+=2(x-y)+5 and y--. Then x++.
  - Loop while x<=y; otherwise go to FINISH.
- Handshake:
  - Once pixel_valid is high, px, py and pixel_color hold stable until a cycle with pixel_ready=1.
  - The FSM advances only on acceptance.
  - Back-to-back acceptance gives 1 pixel/cycle inside a span.
- FINISH:
  - done pulses for one cycle, the cycle after the last accepted (or clipped) pixel.
  - busy drops in the same cycle; return to IDLE.
- r=0: exactly one candidate (xc,yc) in both modes.
- Abort: in any busy state, the next cycle has pixel_valid=0 and busy=0, state is IDLE, no done pulse, and pixel_count holds its value. Abort takes priority over pixel acceptance in the same cycle.
- Reset mid-job: immediate return to the reset state.

Decomposition:
- Shared package gpu_raster_pkg holds:
  - the state enum;
  - the octant order constant;
  - a function for internal signed coordinate width;
  - the default SCREEN_W/SCREEN_H, shared with line/rect blocks.
- One natural sub-module, raster_pix_out: the output register stage holding px/py/color stable under backpressure and performing the clip test.

Test Plan:
- Fill, xc=10, yc=10, r=2, ready=1: 13 pixels. Rows y=8:{10}, y=9:{9..11}, y=10:{8..12}, y=11:{9..11}, y=12:{10}, in that order. Then done pulse; pixel_count=13.
- Fill, xc=0, yc=0, r=2: clipped to 6 pixels: y=0:{0..2}, y=1:{0,1}, y=2:{0}. No negative coordinates appear; pixel_count=6.
- Outline, xc=5, yc=5, r=1: 8 accepted pixels in octant order, covering the set {(5,6),(5,4),(6,5),(4,5)}, each twice. Then done.
- Fill, xc=128, yc=128, r=40, with pixel_ready toggling randomly: px/py stable while valid&&!ready. The accepted stream matches the ready=1 run exactly. Colour F5DEB3 on every pixel.
- Abort after the 5th accepted pixel of fill r=10: next cycle busy=0 and pixel_valid=0, no done pulse, pixel_count=5. A following start at (40,40) with r=0 emits (40,40) only.
- Start asserted while busy and r=0 at (255,255): the extra start is ignored. The r=0 job emits a single pixel (255,255) and done.

Source files
------------

// File: rtl/gpu_raster_pkg.sv
// Shared definitions for the 2D raster blocks: FSM states, circle octant order,
// internal signed coordinate sizing and the default screen dimensions.
package gpu_raster_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROW_INIT,
      ST_SPAN,
      ST_OCT,
      ST_STEP,
      ST_FINISH
   } raster_state_e;

   localparam int DEFAULT_SCREEN_W = 256;
   localparam int DEFAULT_SCREEN_H = 256;

   // Entry i sits at bits [3i+2:3i]: bit2 swaps x/y, bit1 negates the x offset, bit0 the y offset.
   localparam logic [23:0] OCT_ORDER = {3'b111, 3'b101, 3'b110, 3'b100,
                                        3'b011, 3'b001, 3'b010, 3'b000};

   // Two guard bits let centre +/- offset go negative or past the screen without wrapping.
   function automatic int coord_iw(input int coord_w);
      return coord_w + 2;
   endfunction

endpackage

// File: rtl/raster_pix_out.sv
// Output register stage: clips a candidate against the screen and holds the
// pixel stable until the sink accepts it.
module raster_pix_out
   import gpu_raster_pkg::*;
#(
   parameter int COORD_W  = 8,
   parameter int COLOR_W  = 24,
   parameter int SCREEN_W = DEFAULT_SCREEN_W,
   parameter int SCREEN_H = DEFAULT_SCREEN_H,
   parameter int CW       = coord_iw(COORD_W)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 load,
   input  logic signed [CW-1:0] cand_x,
   input  logic signed [CW-1:0] cand_y,
   input  logic [COLOR_W-1:0]   cand_color,
   input  logic                 pixel_ready,
   output logic                 load_ok,
   output logic                 accept,
   output logic                 pixel_valid,
   output logic [COORD_W-1:0]   px,
   output logic [COORD_W-1:0]   py,
   output logic [COLOR_W-1:0]   pixel_color
);

   logic               valid_q, valid_d;
   logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic               in_screen;

   assign in_screen = !cand_x[CW-1] && (int'(cand_x) < SCREEN_W) &&
                      !cand_y[CW-1] && (int'(cand_y) < SCREEN_H);

   assign load_ok     = !valid_q || pixel_ready;
   assign accept      = valid_q && pixel_ready && !flush;
   assign pixel_valid = valid_q;
   assign px          = px_q;
   assign py          = py_q;
   assign pixel_color = color_q;

   // A clipped candidate still loads, but as an empty slot for one cycle.
   always_comb begin
      valid_d = valid_q;
      px_d    = px_q;
      py_d    = py_q;
      color_d = color_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = in_screen;
         px_d    = cand_x[COORD_W-1:0];
         py_d    = cand_y[COORD_W-1:0];
         color_d = cand_color;
      end else if (pixel_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         color_q <= '0;
      end else begin
         valid_q <= valid_d;
         px_q    <= px_d;
         py_q    <= py_d;
         color_q <= color_d;
      end
   end

endmodule

// File: rtl/circle_raster_gen.sv
// Circle rasteriser: filled scanline spans or midpoint outline, streamed one
// candidate per accepted pixel through the clipping output stage.
module circle_raster_gen
   import gpu_raster_pkg::*;
#(
   parameter int COORD_W  = 8,
   parameter int COLOR_W  = 24,
   parameter int SCREEN_W = DEFAULT_SCREEN_W,
   parameter int SCREEN_H = DEFAULT_SCREEN_H
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [COORD_W-1:0]     xc,
   input  logic [COORD_W-1:0]     yc,
   input  logic [COORD_W-1:0]     r,
   input  logic                   fill_enable,
   input  logic [COLOR_W-1:0]     color,
   output logic                   busy,
   output logic                   pixel_valid,
   input  logic                   pixel_ready,
   output logic [COORD_W-1:0]     px,
   output logic [COORD_W-1:0]     py,
   output logic [COLOR_W-1:0]     pixel_color,
   output logic                   done,
   output logic [2*COORD_W+1:0]   pixel_count
);

   localparam int CW = coord_iw(COORD_W);
   localparam int EW = 2*COORD_W + 3;
   localparam int NW = 2*COORD_W + 2;

   raster_state_e        state_q, state_d;
   logic signed [CW-1:0] xc_q, xc_d, yc_q, yc_d, r_q, r_d;
   logic signed [CW-1:0] dy_q, dy_d, w_q, w_d, sx_q, sx_d;
   logic signed [CW-1:0] ox_q, ox_d, oy_q, oy_d;
   logic signed [EW-1:0] d_q, d_d;
   logic [2:0]           idx_q, idx_d;
   logic [COLOR_W-1:0]   color_q, color_d;
   logic [NW-1:0]        count_q, count_d;
   logic                 done_q, done_d;

   logic signed [CW-1:0] r_in, cand_x, cand_y, oct_a, oct_b;
   logic signed [EW-1:0] w_e, dy_e, r_e, ox_e, oy_e, dy_sq, r_sq;
   logic [2:0]           code;
   logic                 w_grow, w_shrink, dy_pos;
   logic                 flush, load, load_ok, accept;

   assign r_in     = {2'b00, r};
   assign w_e      = EW'(w_q);
   assign dy_e     = EW'(dy_q);
   assign r_e      = EW'(r_q);
   assign ox_e     = EW'(ox_q);
   assign oy_e     = EW'(oy_q);
   assign dy_sq    = dy_e * dy_e;
   assign r_sq     = r_e * r_e;
   assign w_grow   = ((w_e + EW'(1)) * (w_e + EW'(1))) + dy_sq <= r_sq;
   assign w_shrink = (w_e * w_e) + dy_sq > r_sq;
   assign dy_pos   = !dy_q[CW-1] && (dy_q != '0);

   assign code  = OCT_ORDER[({1'b0, idx_q, 1'b0} + {2'b00, idx_q}) +: 3];
   assign oct_a = code[2] ? oy_q : ox_q;
   assign oct_b = code[2] ? ox_q : oy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         xc_q    <= '0;
         yc_q    <= '0;
         r_q     <= '0;
         dy_q    <= '0;
         w_q     <= '0;
         sx_q    <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         d_q     <= '0;
         idx_q   <= '0;
         color_q <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xc_q    <= xc_d;
         yc_q    <= yc_d;
         r_q     <= r_d;
         dy_q    <= dy_d;
         w_q     <= w_d;
         sx_q    <= sx_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         d_q     <= d_d;
         idx_q   <= idx_d;
         color_q <= color_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      xc_d    = xc_q;
      yc_d    = yc_q;
      r_d     = r_q;
      dy_d    = dy_q;
      w_d     = w_q;
      sx_d    = sx_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      d_d     = d_q;
      idx_d   = idx_q;
      color_d = color_q;
      count_d = accept ? count_q + NW'(1) : count_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               xc_d    = {2'b00, xc};
               yc_d    = {2'b00, yc};
               r_d     = r_in;
               color_d = color;
               count_d = '0;
               idx_d   = '0;
               if (fill_enable) begin
                  dy_d    = -r_in;
                  w_d     = '0;
                  state_d = ST_ROW_INIT;
               end else begin
                  ox_d    = '0;
                  oy_d    = r_in;
                  d_d     = EW'(1) - EW'(r_in);
                  state_d = ST_OCT;
               end
            end
         end
         // Half-width moves one step per cycle; rows only ever widen then narrow.
         ST_ROW_INIT: begin
            if (!dy_pos && w_grow) begin
               w_d = w_q + CW'(1);
            end else if (dy_pos && w_shrink) begin
               w_d = w_q - CW'(1);
            end else begin
               sx_d    = -w_q;
               state_d = ST_SPAN;
            end
         end
         ST_SPAN: begin
            if (load) begin
               if (sx_q == w_q) begin
                  if (dy_q == r_q) begin
                     state_d = ST_FINISH;
                  end else begin
                     dy_d    = dy_q + CW'(1);
                     state_d = ST_ROW_INIT;
                  end
               end else begin
                  sx_d = sx_q + CW'(1);
               end
            end
         end
         ST_OCT: begin
            if (load) begin
               if (r_q == '0) begin
                  state_d = ST_FINISH;
               end else if (idx_q == 3'd7) begin
                  idx_d   = '0;
                  state_d = ST_STEP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_STEP: begin
            if (d_q[EW-1]) begin
               d_d = d_q + ox_e + ox_e + EW'(3);
            end else begin
               d_d  = d_q + ox_e + ox_e - oy_e - oy_e + EW'(5);
               oy_d = oy_q - CW'(1);
            end
            ox_d    = ox_q + CW'(1);
            state_d = (ox_d <= oy_d) ? ST_OCT : ST_FINISH;
         end
         ST_FINISH: begin
            if (!pixel_valid || accept) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end
   end

   always_comb begin
      cand_x = '0;
      cand_y = '0;
      case (state_q)
         ST_SPAN: begin
            cand_x = xc_q + sx_q;
            cand_y = yc_q + dy_q;
         end
         ST_OCT: begin
            cand_x = xc_q + (code[1] ? -oct_a : oct_a);
            cand_y = yc_q + (code[0] ? -oct_b : oct_b);
         end
         default: begin
            cand_x = '0;
            cand_y = '0;
         end
      endcase
   end

   assign flush       = abort && (state_q != ST_IDLE);
   assign load        = load_ok && !flush && ((state_q == ST_SPAN) || (state_q == ST_OCT));
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign pixel_count = count_q;

   raster_pix_out #(
      .COORD_W  (COORD_W),
      .COLOR_W  (COLOR_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .CW       (CW)
   ) u_pix_out (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .load        (load),
      .cand_x      (cand_x),
      .cand_y      (cand_y),
      .cand_color  (color_q),
      .pixel_ready (pixel_ready),
      .load_ok     (load_ok),
      .accept      (accept),
      .pixel_valid (pixel_valid),
      .px          (px),
      .py          (py),
      .pixel_color (pixel_color)
   );

endmodule
